mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the unified word-addressed memory (combinational read while read-enable is high; write on posedge clk).
- Port 0 is the multicycle CPU datapath. Port 1 is a loader/debug master.
- Each access takes a fixed 3-state sequence: grant, access, response. One access is in flight at a time.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter.
//   state_t   : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   PORT_CPU  : index of port 0 (multicycle CPU datapath)
//   PORT_LDR  : index of port 1 (loader / debug master)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the two requesters.
//
// Build option: MEM_ARB_RR_EN
//   defined   : round-robin; on a tie the port not granted last wins.
//   undefined : fixed priority, port 0 always wins a tie; no pointer input.
//
// Ports:
//   req0, req1  in  request levels of port 0 / port 1
//   last_grant  in  port granted most recently (MEM_ARB_RR_EN builds only)
//   any         out at least one request is pending
//   winner      out index of the winning port (meaningful only when any=1)
// ---------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any,
  output logic winner
);

  always_comb begin
    any    = req0 | req1;
    winner = PORT_CPU;
`ifdef MEM_ARB_RR_EN
    if (req0 && req1) begin
      // Tie: hand the grant to whichever port did not win last time.
      winner = ~last_grant;
    end else if (req1) begin
      winner = PORT_LDR;
    end else begin
      winner = PORT_CPU;
    end
`else
    if (req0) begin
      winner = PORT_CPU;
    end else if (req1) begin
      winner = PORT_LDR;
    end
`endif
  end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter and sequencer in front of a unified word-addressed memory
// (combinational read while mem_read is high, write on the rising edge).
// Every access runs IDLE (sample/grant) -> ACCESS -> RESP, one at a time, so
// a request seen in IDLE cycle N is acknowledged in cycle N+2.
//
// Build option: MEM_ARB_RR_EN selects round-robin tie breaking (default is
// fixed priority to port 0, with no last-grant pointer at all).
//
// Parameters:
//   AW  address width (word index handed straight to the memory)
//   DW  data width
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req0/we0/addr0/wdata0    port 0 request (CPU datapath)
//   ack0                     port 0 one-cycle completion pulse
//   req1/we1/addr1/wdata1    port 1 request (loader / debug)
//   ack1                     port 1 one-cycle completion pulse
//   rdata                    registered read data, valid with ack, then held
//   busy                     high in ACCESS and RESP
//   mem_addr, mem_wdata      registered memory address / write data
//   mem_read, mem_write      memory strobes, only ever high in ACCESS
//   mem_rdata                combinational read data from the memory
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,

  output logic [DW-1:0] rdata,
  output logic          busy,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  state_t        r_state;
  state_t        w_next;

  // Grant register: which port owns the access in flight and its direction.
  logic          r_grant;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_any;
  logic          w_win;
  logic          w_take;

`ifdef MEM_ARB_RR_EN
  logic          r_last;
`endif

  mem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
`ifdef MEM_ARB_RR_EN
    .last_grant (r_last),
`endif
    .any        (w_any),
    .winner     (w_win)
  );

  // A grant is taken only while idle; requests elsewhere are ignored.
  assign w_take = (r_state == IDLE) && w_any;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant / address / data capture in IDLE, read data capture in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= PORT_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_grant <= w_win;
        r_we    <= (w_win == PORT_LDR) ? we1    : we0;
        r_addr  <= (w_win == PORT_LDR) ? addr1  : addr0;
        r_wdata <= (w_win == PORT_LDR) ? wdata1 : wdata0;
      end
      // Writes leave rdata untouched so the last read value stays visible.
      if ((r_state == ACCESS) && !r_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-granted pointer; starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= PORT_LDR;
    end else if (w_take) begin
      r_last <= w_win;
    end
  end
`endif

  // Next-state and output decode.
  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_read  = ~r_we;
        mem_write = r_we;
        w_next    = RESP;
      end
      RESP: begin
        busy   = 1'b1;
        ack0   = (r_grant == PORT_CPU);
        ack1   = (r_grant == PORT_LDR);
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata;

  // Behavioural memory attached to the arbiter.
  logic [DW-1:0] mem [0:255];
  logic          mem_clr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : '0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: expected memory contents, held read data and
  // the port granted most recently.
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] m_rdata;
  logic          m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_pick(input logic r0, input logic r1);
`ifdef MEM_ARB_RR_EN
    if (r0 && r1) return (m_last == 1'b0) ? 1'b1 : 1'b0;
`endif
    return r0 ? 1'b0 : 1'b1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".ack0"},  ack0, 0);
    check({tag, ".ack1"},  ack1, 0);
    check({tag, ".rd"},    mem_read, 0);
    check({tag, ".wr"},    mem_write, 0);
    check({tag, ".rdata"}, rdata, m_rdata);
  endtask

  // One idle cycle with no request: the arbiter must stay idle.
  task automatic idle_cycle();
    @(negedge clk);
    req0 = 0; req1 = 0;
    check_quiet("idle");
  endtask

  // Full transaction starting in an IDLE cycle.
  //   post_mode 0: drop all requests after the grant
  //   post_mode 1: drive random garbage after the grant (must be ignored)
  //   rst_mid   : assert reset during the ACCESS cycle
  task automatic txn(input logic r0, input logic r1,
                     input logic w0, input logic w1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input int post_mode, input bit rst_mid, input string tag);
    logic          win, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    check_quiet({tag, ".idle"});
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    win = model_pick(r0, r1);
    ewe = win ? w1 : w0;
    ea  = win ? a1 : a0;
    ed  = win ? d1 : d0;
    m_last = win;

    // ACCESS cycle
    @(negedge clk);
    if (post_mode == 1) begin
      req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = AW'($urandom_range(0, 15)); addr1 = AW'($urandom_range(0, 15));
      wdata0 = $urandom; wdata1 = $urandom;
    end else begin
      req0 = 0; req1 = 0;
    end
    check({tag, ".acc.busy"}, busy, 1);
    check({tag, ".acc.wr"},   mem_write, ewe);
    check({tag, ".acc.rd"},   mem_read, !ewe);
    check({tag, ".acc.addr"}, mem_addr, ea);
    if (ewe) check({tag, ".acc.wdata"}, mem_wdata, ed);
    check({tag, ".acc.ack0"}, ack0, 0);
    check({tag, ".acc.ack1"}, ack1, 0);
    if (ewe) ref_mem[ea[7:0]] = ed;
    else     m_rdata = ref_mem[ea[7:0]];

    if (rst_mid) begin
      reset = 1;
      m_rdata = '0;
      m_last  = 1'b1;
      @(negedge clk);
      reset = 0;
      req0 = 0; req1 = 0;
      check({tag, ".rst.busy"}, busy, 0);
      check({tag, ".rst.ack0"}, ack0, 0);
      check({tag, ".rst.ack1"}, ack1, 0);
      check({tag, ".rst.wr"},   mem_write, 0);
      check({tag, ".rst.addr"}, mem_addr, 0);
      check({tag, ".rst.rdata"}, rdata, 0);
      check({tag, ".rst.mem"},  mem[ea[7:0]], ed);
    end else begin
      // RESP cycle
      @(negedge clk);
      check({tag, ".resp.busy"},  busy, 1);
      check({tag, ".resp.ack0"},  ack0, (win == 1'b0));
      check({tag, ".resp.ack1"},  ack1, (win == 1'b1));
      check({tag, ".resp.rd"},    mem_read, 0);
      check({tag, ".resp.wr"},    mem_write, 0);
      check({tag, ".resp.rdata"}, rdata, m_rdata);
      req0 = 0; req1 = 0;
    end
  endtask

  initial begin
    logic r0, r1;
    reset = 1; mem_clr = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    m_rdata = '0;
    m_last  = 1'b1;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset.addr",  mem_addr, 0);
    check("reset.wdata", mem_wdata, 0);
    reset = 0; mem_clr = 0;
    idle_cycle();

    // Write then read back through the other port.
    txn(1, 0, 1, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, "wr5");
    check("wr5.mem", mem[5], 32'hDEADBEEF);
    txn(0, 1, 0, 0, 0, 5, 0, 0, 0, 0, "rd5");
    check("rd5.rdata", rdata, 32'hDEADBEEF);

    // Tie held across four transactions.
    for (int k = 0; k < 4; k++) begin
      txn(1, 1, 0, 0, 5, 5, 0, 0, 0, 0, $sformatf("tie%0d", k));
    end
    idle_cycle();

    // Request dropped right after the grant still completes.
    txn(0, 1, 0, 1, 0, 7, 0, 32'hA5A5_0707, 0, 0, "wr7");
    txn(1, 0, 0, 0, 7, 0, 0, 0, 0, 0, "drop7");
    check("drop7.rdata", rdata, 32'hA5A5_0707);

    // Reset during the ACCESS cycle of a write.
    txn(1, 0, 1, 0, 9, 0, 32'h1234, 0, 0, 1, "rstwr9");
    idle_cycle();
    txn(0, 1, 0, 0, 0, 9, 0, 0, 1, 0, "rd9");
    check("rd9.rdata", rdata, 32'h1234);

    // Randomized traffic with idle gaps and ignored post-grant inputs.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      txn(r0, r1, 1'($urandom), 1'($urandom),
          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
          $urandom, $urandom, 1, 0, $sformatf("rnd%0d", n));
    end

    idle_cycle();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound: the run must never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_arbiter
